fptoint: RTL and testbench

FPTOINT -- requirements
Module: fptoint

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_unpack.sv | 25 ++
 rtl/fptoint.sv | 158 +++++++++++++++
 tb/tb_fptoint.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision constants and FSM types for the float-to-integer
// converter and its sibling FP datapaths.
package fp_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_SHIFT  = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4
  } fptoint_state_t;

  // Operand class decided in UNPACK and consumed in FINISH.
  typedef enum logic [2:0] {
    K_ZERO = 3'd0,
    K_NUM  = 3'd1,
    K_OVF  = 3'd2,
    K_MIN  = 3'd3,
    K_NAN  = 3'd4
  } fptoint_kind_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split/classify of an IEEE-754 single operand. is_zero covers
// zero and denormals; mant carries the hidden bit for normals.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       operand,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W:0]   mant,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  logic [FRAC_W-1:0] frac;

  assign sign    = operand[31];
  assign exp     = operand[30:23];
  assign frac    = operand[22:0];
  assign mant    = {exp != '0, frac};
  assign is_zero = (exp == '0);
  assign is_inf  = (exp == EXP_ONES) && (frac == '0);
  assign is_nan  = (exp == EXP_ONES) && (frac != '0);

endmodule

// File: rtl/fptoint.sv
// Multi-cycle float-to-int32 converter, one shift per cycle. Define
// FPTOINT_RNE_EN for round-to-nearest-even instead of truncation.
// Handshake: start is accepted only in IDLE or DONE (busy=0); done then stays
// high with result/flags stable until the next accepted start or reset.
module fptoint
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [31:0]    dataa,
  output logic [31:0]    result,
  output logic           done,
  output logic           busy,
  output logic           overflow,
  output logic           invalid,
  output fptoint_state_t state
);

  logic [31:0]        opnd;
  logic [31:0]        mag;
  logic [31:0]        rnd;
  logic               sgn;
  logic               shl;
  logic [4:0]         cnt;
  fptoint_kind_t      kind;
  logic               u_sign;
  logic [EXP_W-1:0]   u_exp;
  logic [FRAC_W:0]    u_mant;
  logic               u_zero;
  logic               u_inf;
  logic               u_nan;
  logic signed [9:0]  e;
`ifdef FPTOINT_RNE_EN
  logic               guard;
  logic               sticky;
`endif

  fp_unpack u_unpack (
    .operand (opnd),
    .sign    (u_sign),
    .exp     (u_exp),
    .mant    (u_mant),
    .is_zero (u_zero),
    .is_inf  (u_inf),
    .is_nan  (u_nan)
  );

  assign e = 10'({2'b00, u_exp}) - 10'(FP_BIAS);

  always_comb begin
    rnd = mag;
`ifdef FPTOINT_RNE_EN
    if (guard && (sticky || mag[0])) rnd = mag + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      opnd     <= '0;
      mag      <= '0;
      sgn      <= 1'b0;
      shl      <= 1'b0;
      cnt      <= '0;
      kind     <= K_ZERO;
`ifdef FPTOINT_RNE_EN
      guard    <= 1'b0;
      sticky   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            opnd     <= dataa;
            done     <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sgn   <= u_sign;
          mag   <= {8'b0, u_mant};
          kind  <= K_NUM;
          state <= S_FINISH;
`ifdef FPTOINT_RNE_EN
          guard  <= 1'b0;
          sticky <= 1'b0;
`endif
          if (u_nan)       kind <= K_NAN;
          else if (u_inf)  kind <= K_OVF;
          else if (u_zero) kind <= K_ZERO;
          else if (e >= 10'sd31) begin
            // -2^31 is exactly representable, so it is not an overflow.
            kind <= (opnd == 32'hCF00_0000) ? K_MIN : K_OVF;
          end else if (e < 10'sd0) begin
`ifdef FPTOINT_RNE_EN
            if (e == -10'sd1) begin
              shl   <= 1'b0;
              cnt   <= 5'd24;
              state <= S_SHIFT;
            end else kind <= K_ZERO;
`else
            kind <= K_ZERO;
`endif
          end else if (e > 10'sd23) begin
            shl   <= 1'b1;
            cnt   <= 5'(e - 10'sd23);
            state <= S_SHIFT;
          end else if (e < 10'sd23) begin
            shl   <= 1'b0;
            cnt   <= 5'(10'sd23 - e);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (shl) mag <= {mag[30:0], 1'b0};
          else begin
            mag <= {1'b0, mag[31:1]};
`ifdef FPTOINT_RNE_EN
            guard  <= mag[0];
            sticky <= sticky | guard;
`endif
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= S_FINISH;
        end
        S_FINISH: begin
          case (kind)
            K_NUM:   result <= sgn ? (~rnd + 32'd1) : rnd;
            K_OVF: begin
              result   <= sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
              overflow <= 1'b1;
            end
            K_MIN:   result <= 32'h8000_0000;
            K_NAN: begin
              result  <= '0;
              invalid <= 1'b1;
            end
            default: result <= '0;
          endcase
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fptoint.sv
// Directed-vector bench for fptoint: driver pushes expectations, a negedge
// monitor pops and checks result, flags and latency on each rising done.
module tb_fptoint;
  import fp_pkg::*;

`ifdef FPTOINT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  localparam int W = 42;

  logic           clk;
  logic           reset;
  logic           start;
  logic [31:0]    dataa;
  logic [31:0]    result;
  logic           done;
  logic           busy;
  logic           overflow;
  logic           invalid;
  fptoint_state_t state;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           cyc;
  int           n_vec;
  int           n_chk;
  int           n_fail;
  int           n_done;
  logic         done_d;

  fptoint dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dataa    (dataa),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .overflow (overflow),
    .invalid  (invalid),
    .state    (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // monitor / scoreboard
  initial done_d = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           a;
    if (done && !done_d) begin
      n_done++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with result %h, expected no done", result);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("result",   result,            e[41:10]);
        chk("overflow", {31'b0, overflow}, {31'b0, e[9]});
        chk("invalid",  {31'b0, invalid},  {31'b0, e[8]});
        chk("latency",  32'(cyc - a),      {24'b0, e[7:0]});
      end
    end
    done_d = done;
  end

  // driver
  task automatic run_vec(input logic [31:0] d, input logic [31:0] r, input logic o,
                         input logic i, input int lat, input bit pulse);
    int  seen;
    bit  from_done;
    @(negedge clk);
    from_done = done;
    seen = n_done;
    exp_q.push_back({r, o, i, 8'(lat)});
    start = 1'b1;
    dataa = d;
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    start = 1'b0;
    dataa = $urandom;
    n_vec++;
    if (from_done) chk("relaunch_done_drop", {31'b0, done}, 32'd0);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    if (pulse) begin
      repeat ($urandom_range(3, 6)) @(negedge clk);
      start = 1'b1;
      dataa = 32'h4228_0000;
      chk("busy_during_pulse", {31'b0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 40 && n_done == seen; k++) @(negedge clk);
    if (n_done == seen) begin
      n_fail++;
      $display("FAIL done_timeout: got no done for %h, expected done within %0d edges", d, lat);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    n_vec = 0; n_chk = 0; n_fail = 0; n_done = 0;
    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result",   result,            32'd0);
    chk("rst_done",     {31'b0, done},     32'd0);
    chk("rst_busy",     {31'b0, busy},     32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_invalid",  {31'b0, invalid},  32'd0);
    chk("rst_state",    32'(state),        32'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;

    run_vec(32'h4070_0000, RNE ? 32'd4 : 32'd3, 1'b0, 1'b0, 24, 1'b0);  // 3.75
    run_vec(32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 24, 1'b0);        // -2.5
    run_vec(32'h3F40_0000, RNE ? 32'd1 : 32'd0, 1'b0, 1'b0, RNE ? 26 : 2, 1'b0); // 0.75
    run_vec(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 1'b0);         // 2^31
    run_vec(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2, 1'b0);         // -2^31
    run_vec(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2, 1'b0);         // -inf
    run_vec(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 1'b0);         // +inf
    run_vec(32'h7FC0_0000, 32'd0, 1'b0, 1'b1, 2, 1'b0);                 // NaN
    run_vec(32'h0000_0001, 32'd0, 1'b0, 1'b0, 2, 1'b0);                 // denormal
    run_vec(32'h8000_0000, 32'd0, 1'b0, 1'b0, 2, 1'b0);                 // -0
    run_vec(32'h4228_0000, 32'd42, 1'b0, 1'b0, 20, 1'b0);               // 42.0
    run_vec(32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2, 1'b0);         // 2^23, no shift
    run_vec(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9, 1'b0);         // largest e=30
    run_vec(32'h3F80_0000, 32'd1, 1'b0, 1'b0, 25, 1'b1);                // 1.0, start pulsed while busy
    run_vec(32'hBFC0_0000, RNE ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b0, 1'b0, 25, 1'b0); // -1.5
    run_vec(32'h3F00_0000, 32'd0, 1'b0, 1'b0, RNE ? 26 : 2, 1'b0);      // 0.5 ties to even
    run_vec(32'h3E80_0000, 32'd0, 1'b0, 1'b0, 2, 1'b0);                 // 0.25

    // reset in the middle of SHIFT aborts with no done
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_state", 32'(state), 32'(S_SHIFT));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_result",   result,            32'd0);
    chk("abort_done",     {31'b0, done},     32'd0);
    chk("abort_busy",     {31'b0, busy},     32'd0);
    chk("abort_overflow", {31'b0, overflow}, 32'd0);
    chk("abort_invalid",  {31'b0, invalid},  32'd0);
    chk("abort_state",    32'(state),        32'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", {31'b0, done}, 32'd0);

    run_vec(32'h4070_0000, RNE ? 32'd4 : 32'd3, 1'b0, 1'b0, 24, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
